// File: rtl/fft_pkg.sv
// Shared FFT output-side definitions: component width, lane count, complex pair type.
// Pure declarations; no logic and no latency.
// No flow control lives here.
package fft_pkg;

    localparam int FFT_BIT     = 17;
    localparam int FFT_LANES   = 4;
    localparam int FFT_LANE_W  = $clog2(FFT_LANES);

    typedef struct packed {
        logic [FFT_BIT-1:0] re;
        logic [FFT_BIT-1:0] im;
    } fft_cplx_t;

    // The lane counter wraps at FFT_LANES, which is a power of two.
    function automatic logic [FFT_LANE_W-1:0] lane_next(input logic [FFT_LANE_W-1:0] lane);
        return lane + 1'b1;
    endfunction

    function automatic logic lane_is_last(input logic [FFT_LANE_W-1:0] lane);
        return lane == FFT_LANE_W'(FFT_LANES - 1);
    endfunction

endpackage

// File: rtl/fft_out_serializer_if.sv
// Four-lane complex input word plus serial complex output stream with frame markers.
// Wires only; no latency.
// Valid/ready on both sides: iVALID/oREADY in, oVALID/iREADY out.
interface fft_out_serializer_if #(
    parameter int BIT    = 17,
    parameter int N_LOG2 = 8
);
    logic [BIT-1:0]    iX0_RE;
    logic [BIT-1:0]    iX0_IM;
    logic [BIT-1:0]    iX1_RE;
    logic [BIT-1:0]    iX1_IM;
    logic [BIT-1:0]    iX2_RE;
    logic [BIT-1:0]    iX2_IM;
    logic [BIT-1:0]    iX3_RE;
    logic [BIT-1:0]    iX3_IM;
    logic              iVALID;
    logic              oREADY;
    logic [BIT-1:0]    oRE;
    logic [BIT-1:0]    oIM;
    logic              oVALID;
    logic              iREADY;
    logic [N_LOG2-1:0] oIDX;
    logic              oSOF;
    logic              oEOF;

    // Upstream mix stage plus downstream sink, seen as one environment.
    modport master (
        output iX0_RE, iX0_IM, iX1_RE, iX1_IM,
        output iX2_RE, iX2_IM, iX3_RE, iX3_IM,
        output iVALID, iREADY,
        input  oREADY, oRE, oIM, oVALID, oIDX, oSOF, oEOF
    );

    modport slave (
        input  iX0_RE, iX0_IM, iX1_RE, iX1_IM,
        input  iX2_RE, iX2_IM, iX3_RE, iX3_IM,
        input  iVALID, iREADY,
        output oREADY, oRE, oIM, oVALID, oIDX, oSOF, oEOF
    );

endinterface

// File: rtl/fft_out_bank.sv
// One 4-lane complex register bank with whole-word write enable and a lane read mux.
// Write lands on the clock edge; read is combinational from the stored lanes.
// No flow control; the owner decides when to write and which lane to read.
module fft_out_bank
    import fft_pkg::*;
#(
    parameter type T = fft_cplx_t
) (
    input  logic                  iCLK,
    input  logic                  iRESET,
    input  logic                  i_we,
    input  T [FFT_LANES-1:0]      i_wdat,
    input  logic [FFT_LANE_W-1:0] i_sel,
    output T                      o_rdat
);

    T [FFT_LANES-1:0] r_lane;

    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            r_lane <= '0;
        end else if (i_we) begin
            r_lane <= i_wdat;
        end
    end

    assign o_rdat = r_lane[i_sel];

endmodule

// File: rtl/fft_out_serializer.sv
// Ping-pong serializer: 4-lane complex words in, one complex sample per cycle out.
// Latency 1 cycle from accept to lane 0; optional frame index/SOF/EOF under FFT_OUT_FRAME_EN.
// oREADY while a bank is empty (registered only); output holds while iREADY is low.
module fft_out_serializer
    import fft_pkg::*;
#(
    parameter int BIT    = FFT_BIT,
    parameter int N_LOG2 = 8
) (
    input  logic                iCLK,
    input  logic                iRESET,
    fft_out_serializer_if.slave bus
);

    typedef struct packed {
        logic [BIT-1:0] re;
        logic [BIT-1:0] im;
    } cplx_t;

    logic [1:0]            r_full;
    logic [1:0]            w_full_nxt;
    logic                  r_wptr;
    logic                  r_rptr;
    logic                  r_run;
    logic [FFT_LANE_W-1:0] r_lane;
    logic [FFT_LANE_W-1:0] w_lane_nxt;
    logic                  w_rptr_nxt;
    logic                  w_wptr_nxt;

    logic                  w_rdy;
    logic                  w_vld;
    logic                  w_acc;
    logic                  w_xfer;
    logic                  w_last;
    logic [1:0]            w_we;

    cplx_t [FFT_LANES-1:0] w_wdat;
    cplx_t                 w_rd [2];
    cplx_t                 w_sel;

    // r_run keeps oREADY low through reset and rises on the first edge after release.
    assign w_rdy  = r_run & ~(r_full[0] & r_full[1]);
    assign w_vld  = r_full[r_rptr];
    assign w_acc  = bus.iVALID & w_rdy;
    assign w_xfer = w_vld & bus.iREADY;
    assign w_last = w_xfer & lane_is_last(r_lane);

    always_comb begin
        w_wdat[0].re = bus.iX0_RE;
        w_wdat[0].im = bus.iX0_IM;
        w_wdat[1].re = bus.iX1_RE;
        w_wdat[1].im = bus.iX1_IM;
        w_wdat[2].re = bus.iX2_RE;
        w_wdat[2].im = bus.iX2_IM;
        w_wdat[3].re = bus.iX3_RE;
        w_wdat[3].im = bus.iX3_IM;
    end

    // Banks fill and drain in the same order, so whenever any bank is empty
    // the write pointer already points at it; accept and drain never collide.
    always_comb begin
        w_full_nxt = r_full;
        w_lane_nxt = r_lane;
        w_rptr_nxt = r_rptr;
        w_wptr_nxt = r_wptr;
        w_we       = 2'b00;
        if (w_xfer) begin
            w_lane_nxt = lane_next(r_lane);
        end
        if (w_last) begin
            w_full_nxt[r_rptr] = 1'b0;
            w_lane_nxt         = '0;
            w_rptr_nxt         = ~r_rptr;
        end
        if (w_acc) begin
            w_full_nxt[r_wptr] = 1'b1;
            w_we[r_wptr]       = 1'b1;
            w_wptr_nxt         = ~r_wptr;
        end
    end

    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            r_full <= 2'b00;
            r_wptr <= 1'b0;
            r_rptr <= 1'b0;
            r_lane <= '0;
            r_run  <= 1'b0;
        end else begin
            r_full <= w_full_nxt;
            r_wptr <= w_wptr_nxt;
            r_rptr <= w_rptr_nxt;
            r_lane <= w_lane_nxt;
            r_run  <= 1'b1;
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        fft_out_bank #(
            .T (cplx_t)
        ) u_bank (
            .iCLK   (iCLK),
            .iRESET (iRESET),
            .i_we   (w_we[b]),
            .i_wdat (w_wdat),
            .i_sel  (r_lane),
            .o_rdat (w_rd[b])
        );
    end

    assign w_sel      = r_rptr ? w_rd[1] : w_rd[0];
    assign bus.oREADY = w_rdy;
    assign bus.oVALID = w_vld;
    assign bus.oRE    = w_sel.re;
    assign bus.oIM    = w_sel.im;

`ifdef FFT_OUT_FRAME_EN
    logic [N_LOG2-1:0] r_idx;

    // The index wraps naturally at 2^N_LOG2.
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            r_idx <= '0;
        end else if (w_xfer) begin
            r_idx <= r_idx + 1'b1;
        end
    end

    assign bus.oIDX = r_idx;
    assign bus.oSOF = w_vld & (r_idx == '0);
    assign bus.oEOF = w_vld & (r_idx == '1);
`else
    assign bus.oIDX = '0;
    assign bus.oSOF = 1'b0;
    assign bus.oEOF = 1'b0;
`endif

endmodule

// File: tb/tb_fft_out_serializer.sv
// Directed bench for fft_out_serializer: reset, single word, back-to-back, stalls, mid-frame reset, extremes.
// Frame checks follow FFT_OUT_FRAME_EN with N_LOG2=3.
module tb_fft_out_serializer;

    localparam int BIT    = 17;
    localparam int N_LOG2 = 3;
`ifdef FFT_OUT_FRAME_EN
    localparam bit FRAME  = 1'b1;
`else
    localparam bit FRAME  = 1'b0;
`endif

    logic iCLK;
    logic iRESET;
    int   errors;
    int   checks;
    int   nout;
    logic [BIT-1:0] w_re [4];
    logic [BIT-1:0] w_im [4];

    fft_out_serializer_if #(.BIT(BIT), .N_LOG2(N_LOG2)) bus ();

    fft_out_serializer #(.BIT(BIT), .N_LOG2(N_LOG2)) dut (
        .iCLK   (iCLK),
        .iRESET (iRESET),
        .bus    (bus)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge iCLK);
        #1;
    endtask

    task automatic load();
        bus.iX0_RE = w_re[0]; bus.iX0_IM = w_im[0];
        bus.iX1_RE = w_re[1]; bus.iX1_IM = w_im[1];
        bus.iX2_RE = w_re[2]; bus.iX2_IM = w_im[2];
        bus.iX3_RE = w_re[3]; bus.iX3_IM = w_im[3];
    endtask

    task automatic set_word(input int base);
        for (int k = 0; k < 4; k++) begin
            w_re[k] = 17'(base + k);
            w_im[k] = 17'(-(base + k));
        end
        load();
    endtask

    task automatic exp_cx(input string tag, input logic [BIT-1:0] re, input logic [BIT-1:0] im, input bit xfer);
        int idx;
        idx = FRAME ? (nout % 8) : 0;
        chk({tag, ".vld"}, bus.oVALID, 1);
        chk({tag, ".re"},  bus.oRE, re);
        chk({tag, ".im"},  bus.oIM, im);
        chk({tag, ".idx"}, bus.oIDX, idx);
        chk({tag, ".sof"}, bus.oSOF, (FRAME && idx == 0) ? 1 : 0);
        chk({tag, ".eof"}, bus.oEOF, (FRAME && idx == 7) ? 1 : 0);
        if (xfer) nout++;
    endtask

    task automatic exp_val(input string tag, input int v, input bit xfer);
        exp_cx(tag, 17'(v), 17'(-v), xfer);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".rdy"}, bus.oREADY, 0);
        chk({tag, ".vld"}, bus.oVALID, 0);
        chk({tag, ".re"},  bus.oRE, 0);
        chk({tag, ".im"},  bus.oIM, 0);
        chk({tag, ".idx"}, bus.oIDX, 0);
        chk({tag, ".sof"}, bus.oSOF, 0);
        chk({tag, ".eof"}, bus.oEOF, 0);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        nout   = 0;
        iRESET = 1'b0;
        bus.iVALID = 1'b0;
        bus.iREADY = 1'b0;
        set_word(0);

        // Reset state and first-cycle oREADY
        #2;
        chk_all_zero("rst");
        step();
        step();
        iRESET = 1'b1;
        #1;
        chk("rel.rdy0", bus.oREADY, 0);
        step();
        chk("rel.rdy1", bus.oREADY, 1);
        chk("rel.vld0", bus.oVALID, 0);

        // Single word, one-cycle latency, four consecutive samples
        set_word(1);
        bus.iVALID = 1'b1;
        bus.iREADY = 1'b1;
        step();
        bus.iVALID = 1'b0;
        for (int l = 0; l < 4; l++) begin
            chk("single.rdy", bus.oREADY, 1);
            exp_val("single", 1 + l, 1'b1);
            step();
        end
        chk("single.end", bus.oVALID, 0);

        // Back-to-back words: oREADY drops after second accept
        set_word(10);
        bus.iVALID = 1'b1;
        step();
        exp_val("b2b", 10, 1'b1);
        chk("b2b.rdy_a", bus.oREADY, 1);
        set_word(20);
        step();
        bus.iVALID = 1'b0;
        for (int l = 1; l < 4; l++) begin
            exp_val("b2b", 10 + l, 1'b1);
            chk("b2b.rdy_full", bus.oREADY, 0);
            step();
        end
        for (int l = 0; l < 4; l++) begin
            exp_val("b2b", 20 + l, 1'b1);
            chk("b2b.rdy_free", bus.oREADY, 1);
            step();
        end
        chk("b2b.end", bus.oVALID, 0);

        // Alternating iREADY: stalls hold the sample, order preserved
        set_word(40);
        bus.iVALID = 1'b1;
        step();
        bus.iREADY = 1'b0;
        exp_val("stall", 40, 1'b0);
        chk("stall.rdy_a", bus.oREADY, 1);
        set_word(50);
        step();
        bus.iVALID = 1'b0;
        for (int k = 0; k < 15; k++) begin
            int s;
            s = (k + 1) / 2;
            bus.iREADY = (k % 2 == 0);
            exp_val("stall", (s < 4) ? (40 + s) : (46 + s), bus.iREADY);
            chk("stall.rdy", bus.oREADY, (k >= 7) ? 1 : 0);
            step();
        end
        chk("stall.end", bus.oVALID, 0);

        // Reset after two lanes drained
        bus.iREADY = 1'b1;
        set_word(60);
        bus.iVALID = 1'b1;
        step();
        bus.iVALID = 1'b0;
        exp_val("mid", 60, 1'b1);
        step();
        exp_val("mid", 61, 1'b1);
        step();
        chk("mid.pre_re", bus.oRE, 62);
        iRESET = 1'b0;
        nout   = 0;
        #1;
        chk_all_zero("midrst");
        step();
        iRESET = 1'b1;
        #1;
        chk("midrel.rdy0", bus.oREADY, 0);
        step();
        chk("midrel.rdy1", bus.oREADY, 1);
        chk("midrel.vld0", bus.oVALID, 0);
        set_word(70);
        bus.iVALID = 1'b1;
        step();
        bus.iVALID = 1'b0;
        for (int l = 0; l < 4; l++) begin
            exp_val("after", 70 + l, 1'b1);
            step();
        end
        chk("after.end", bus.oVALID, 0);

        // Extreme two's-complement values pass bit-exact
        w_re[0] = 17'h0FFFF; w_im[0] = 17'h10000;
        w_re[1] = 17'h10000; w_im[1] = 17'h0FFFF;
        w_re[2] = 17'h1FFFF; w_im[2] = 17'h00000;
        w_re[3] = 17'h00001; w_im[3] = 17'h1FFFF;
        load();
        bus.iVALID = 1'b1;
        step();
        bus.iVALID = 1'b0;
        exp_cx("max0", 17'h0FFFF, 17'h10000, 1'b1);
        step();
        exp_cx("max1", 17'h10000, 17'h0FFFF, 1'b1);
        step();
        exp_cx("max2", 17'h1FFFF, 17'h00000, 1'b1);
        step();
        exp_cx("max3", 17'h00001, 17'h1FFFF, 1'b1);
        step();
        chk("max.end", bus.oVALID, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fft_out_serializer.md
FFT_OUT_SERIALIZER -- requirements
Module: fft_out_serializer

Interface
REQ-001 SHALL have parameter BIT, default 17, sample width in bits per real/imag component (two's complement).
REQ-002 SHALL have parameter N_LOG2, default 8, log2 of frame length in output samples.
REQ-003 SHALL have port iCLK  input  1  single clock; all state on its rising edge.
REQ-004 SHALL have port iRESET  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports iX0_RE..iX3_IM  input  BIT each  four parallel complex samples from the output mix stage, lane 0 first.
REQ-006 SHALL have port iVALID  input  1  four-lane input word valid.
REQ-007 SHALL have port oREADY  output  1  serializer can accept a word.
REQ-008 SHALL have ports oRE, oIM  output  BIT each  serial complex output sample.
REQ-009 SHALL have port oVALID  output  1  oRE/oIM valid.
REQ-010 SHALL have port iREADY  input  1  downstream accepts the sample.
REQ-011 SHALL have port oIDX  output  N_LOG2  in-frame index of the current output sample.
REQ-012 SHALL have ports oSOF, oEOF  output  1 each  first/last sample of frame markers.

Function
REQ-013 SHALL hold two 4-lane complex banks (ping-pong), each marked full/empty, plus write-bank and read-bank pointers and a 2-bit lane counter.
REQ-014 SHALL accept an input word when iVALID & oREADY at a clock edge: all 8 components stored into the write bank, bank marked full, write pointer toggled.
REQ-015 SHALL drive oREADY = 1 iff at least one bank is empty, from registered state only (no path from iVALID or iREADY).
REQ-016 SHALL drive oVALID = 1 iff the read bank is full; oRE/oIM = read bank lane[lane counter], lane order 0,1,2,3.
REQ-017 SHALL on oVALID & iREADY advance lane counter; on the lane-3 transfer mark read bank empty, clear lane to 0, toggle read pointer.
REQ-018 SHALL present lane 0 of an accepted word on the cycle after acceptance when the other bank is empty (latency 1 cycle).
REQ-019 SHALL support simultaneous accept into the free bank and drain of the other in one cycle with no loss; a bank freed this cycle is reported by oREADY only next cycle.
REQ-020 SHALL sustain one input word per 4 cycles and one output sample per cycle with iREADY held high.
REQ-021 SHALL hold oRE/oIM/oIDX stable while oVALID=1 and iREADY=0.
REQ-022 SHALL pass samples unmodified (no rounding, no saturation, bit-exact).

Reset
REQ-023 SHALL on iRESET low asynchronously clear both banks to 0, mark both empty, clear pointers, lane and frame counters.
REQ-024 SHALL force oREADY=0, oVALID=0, oRE=oIM=0, oIDX=0, oSOF=oEOF=0 while iRESET is low; oREADY rises the first cycle after release.
REQ-025 SHALL discard any partially drained bank on reset mid-frame; the next frame restarts at oIDX=0.

Configuration
REQ-026 SHALL compile frame tracking under macro FFT_OUT_FRAME_EN: when defined, oIDX counts output transfers, wrapping 2^N_LOG2-1 -> 0; oSOF = oVALID & (oIDX==0); oEOF = oVALID & (oIDX==2^N_LOG2-1).
REQ-027 SHALL, without FFT_OUT_FRAME_EN, tie oIDX, oSOF, oEOF to 0 and instantiate no frame counter.

Structure
REQ-028 SHALL take BIT default, lane count (4) and a complex-sample pair typedef from shared package fft_pkg.
REQ-029 SHALL use one sub-module fft_out_bank (one 4-lane complex register bank with write-enable and lane read mux), instantiated twice.

Verification
REQ-030 Single word X0..X3 = (1,-1),(2,-2),(3,-3),(4,-4), iREADY=1 -> oVALID 4 consecutive cycles starting cycle after accept, samples in that order, oREADY stays 1.
REQ-031 Back-to-back words every cycle, iREADY=1 -> oREADY drops after 2nd accept, 8 samples out in order, no drops or duplicates.
REQ-032 iREADY toggled 1010... with continuous input -> output sequence equals input lane sequence, held stable on stalls.
REQ-033 FFT_OUT_FRAME_EN, N_LOG2=3, 3 words -> oSOF on samples 0 and 8, oEOF on sample 7, oIDX 0..7,0..3.
REQ-034 Assert iRESET after 2 of 4 lanes drained -> all outputs 0 immediately; after release, new word emerges from lane 0 with oIDX=0.
REQ-035 Max-magnitude values 0x0FFFF / 0x10000 (BIT=17) -> bit-exact passthrough.
